// File: rtl/byteblast8_pkg.sv
// Shared definitions for the byteblast8 boot path: loader state encoding and
// the default address/data widths used by the RAM and the loader.
package byteblast8_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/prog_loader.sv
// Boot-time program loader. Takes a valid/ready byte stream and writes it into
// RAM from address 0 upward, then releases the CPU through cpu_enable.
// Optional feature macro: LOADER_CHECKSUM_EN -- the in_last byte is treated as a
// checksum over the written bytes instead of being written.
module prog_loader
  import byteblast8_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = ADDR_W,
  parameter int unsigned DATA_BITS    = DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [DATA_BITS-1:0]    in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic                    ram_w_enable,
  output logic [ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]    ram_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    cpu_enable,
  output logic [ADDRESS_BITS:0]   byte_count
);

  localparam logic [ADDRESS_BITS-1:0] LastAddr = '1;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;      // address the next accepted byte goes to
  logic                    wen_q, wen_d;
  logic [ADDRESS_BITS-1:0] waddr_q, waddr_d;
  logic [DATA_BITS-1:0]    wdata_q, wdata_d;
  logic [ADDRESS_BITS:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    load_q, load_d;      // drives both in_ready and busy
  logic                    done_q, done_d;
  logic                    cpu_en_q, cpu_en_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_BITS-1:0]    sum_q, sum_d;
`endif

  logic accept;
  logic wr_byte;

  assign accept = in_valid & load_q;
`ifdef LOADER_CHECKSUM_EN
  // The closing byte carries the checksum and never reaches RAM.
  assign wr_byte = accept & ~in_last;
`else
  assign wr_byte = accept;
`endif

  // Next-state: load sequencing, write staging, counters and error flag.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q + {{ADDRESS_BITS{1'b0}}, wen_q};
    err_d   = err_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          addr_d  = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      StLoad: begin
        if (wr_byte) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          wdata_d = in_data;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + in_data;
`endif
          // The address saturates at the top of RAM; it never wraps.
          if (addr_q != LastAddr) begin
            addr_d = addr_q + ADDRESS_BITS'(1);
          end
          if (in_last) begin
            state_d = StDone;
          end else if (addr_q == LastAddr) begin
            state_d = StDone;
            err_d   = 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        if (accept && in_last) begin
          state_d = StDone;
          err_d   = (sum_q != in_data);
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_comb begin
    load_d   = (state_d == StLoad);
    done_d   = (state_d == StDone);
    cpu_en_d = done_d & ~err_d;
  end

  // State and output registers; reset cancels any pending write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      load_q   <= 1'b0;
      done_q   <= 1'b0;
      cpu_en_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      load_q   <= load_d;
      done_q   <= done_d;
      cpu_en_q <= cpu_en_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign in_ready     = load_q;
  assign busy         = load_q;
  assign done         = done_q;
  assign err          = err_q;
  assign cpu_enable   = cpu_en_q;
  assign ram_w_enable = wen_q;
  assign ram_address  = waddr_q;
  assign ram_data     = wdata_q;
  assign byte_count   = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random and directed byte streams, a reference model
// that predicts the RAM writes and final status, and a write monitor that
// pops predicted writes as the loader strobes RAM.
module tb_prog_loader;

  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int Cap = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit Chk = 1'b1;
`else
  localparam bit Chk = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          ram_w_enable;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_enable;
  logic [AW:0]   byte_count;

  prog_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .ram_w_enable(ram_w_enable),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .cpu_enable  (cpu_enable),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] stim_d[$];
  bit            stim_l[$];
  int            n_tests;
  int            n_fail;
  int            gap_max;

  logic [24:0] outs;
  assign outs = {in_ready, ram_w_enable, ram_address, ram_data, busy, done, err, cpu_enable,
                 byte_count};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: every RAM strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (reset === 1'b1 && ram_w_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 ram_address, ram_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", ram_address, w.a);
        check("write_data", ram_data, w.d);
      end
    end
  end

  // Random stream of n bytes ending in in_last; optionally a correct checksum.
  task automatic gen(input int n, input bit fix_sum);
    int s;
    s = 0;
    stim_d.delete();
    stim_l.delete();
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] b;
      b = DW'($urandom);
      if (i == n - 1 && fix_sum) b = DW'(s);
      s += int'(b);
      stim_d.push_back(b);
      stim_l.push_back(i == n - 1);
    end
  endtask

  // One complete load: predict, start, stream, then check the final status.
  // Entered and left just after a rising edge.
  task automatic run_load(input string tag);
    int n_wr, consumed, accepted, sum;
    bit exp_err, got;
    n_wr = 0; consumed = 0; sum = 0; exp_err = 1'b0;
    for (int i = 0; i < stim_d.size(); i++) begin
      consumed++;
      if (Chk && stim_l[i]) begin
        exp_err = ((sum % (1 << DW)) != int'(stim_d[i]));
        break;
      end
      exp_q.push_back('{a: AW'(n_wr), d: stim_d[i]});
      sum += int'(stim_d[i]);
      n_wr++;
      if (stim_l[i]) break;
      if (n_wr == Cap) begin
        exp_err = 1'b1;
        break;
      end
    end

    // Start pulse with a junk byte offered alongside it; it must not be taken.
    start = 1'b1; in_valid = 1'b1; in_data = DW'($urandom); in_last = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    check({tag, "_start_state"}, {busy, cpu_enable, ram_w_enable, in_ready}, 4'b1001);
    @(posedge clk); #1;

    accepted = 0;
    for (int i = 0; i < stim_d.size(); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = stim_d[i]; in_last = stim_l[i];
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        @(negedge clk);
        got = in_ready;
        @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
      if (!got) break;
      accepted++;
    end
    check({tag, "_accepted"}, accepted, consumed);

    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = done;
    end
    check({tag, "_done"}, got, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_byte_count"}, byte_count, n_wr);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cpu_enable"}, cpu_enable, !exp_err);
    check({tag, "_idle_handshake"}, {busy, in_ready}, 2'b00);
    check({tag, "_writes_pending"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; gap_max = 0;
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    #2;
    check("reset_outputs", outs, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Reset mid-load with a write strobe pending for the second byte.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    exp_q.push_back('{a: AW'(0), d: 8'h11});
    @(posedge clk); #1;
    in_data = 8'h22;
    @(posedge clk); #3;
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("reset_midload_outputs", outs, 0);
    check("reset_midload_first_write", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    // Directed stream from IDLE.
    stim_d = '{8'h23, 8'h44, 8'h85, 8'h02, 8'h05};
    stim_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    gap_max = 0;
    run_load("basic");

    // Gappy valid; restart from DONE.
    gen(7, 1'b1);
    gap_max = 2;
    run_load("gaps");

    // Overflow: 33 bytes without in_last.
    gen(33, 1'b0);
    stim_l[32] = 1'b0;
    gap_max = 0;
    run_load("overflow");

    // Restart after an error; writes must begin at address 0 again.
    gen(3, 1'b1);
    run_load("after_err");

`ifdef LOADER_CHECKSUM_EN
    stim_d = '{8'h02, 8'h05, 8'h07};
    stim_l = '{1'b0, 1'b0, 1'b1};
    run_load("chk_good");
    stim_d = '{8'h02, 8'h05, 8'h08};
    run_load("chk_bad");
    stim_d = '{8'h00};
    stim_l = '{1'b1};
    run_load("chk_only");
`endif

    // Boundary: in_last on the top address, and in_last one byte too late.
    gen(Cap, 1'b1);
    run_load("full");
    gen(Cap + 1, 1'b1);
    run_load("late_last");

    for (int k = 0; k < 10; k++) begin
      gen($urandom_range(1, 36), 1'($urandom));
      gap_max = $urandom_range(0, 2);
      run_load("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
